// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
// Command-side master for a registered 5-bit-opcode ALU.
//
// Behaviour:
//  - Accepts one operation per cmd_valid/cmd_ready handshake.
//  - Presents the operation to the ALU for exactly one cycle.
//  - Captures the registered ALU result one clock later.
//  - Returns the result with status flags on a valid/ready response port.
//
// Every output is a register, so no combinational path runs from rsp_ready
// to cmd_ready. A new command can only be taken in the cycle after the
// response handshake.

module alu_cmd_driver #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    // Opcode map of the attached ALU; anything above OP_LAST is rejected.
    localparam logic [OP_W-1:0] OP_NOP  = '0;
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(6);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_reg;
    logic [OP_W-1:0]   op_reg;        // latched opcode, kept for the overflow rule
    logic [WIDTH-1:0]  alu_a_reg;
    logic [WIDTH-1:0]  alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic              cmd_ready_reg;
    logic              rsp_valid_reg;
    logic [WIDTH-1:0]  rsp_data_reg;
    logic              rsp_zero_reg;
    logic              rsp_neg_reg;
    logic              rsp_ovf_reg;
    logic              rsp_err_reg;
    logic [CNT_W-1:0]  op_count_reg;

    // Flags for the value being captured.
    // alu_a/alu_b still hold the operands that produced alu_out, because
    // they only change when a new command is accepted.
    logic sign_a;
    logic sign_b;
    logic sign_r;
    logic cap_zero;
    logic cap_neg;
    logic cap_ovf;

    assign sign_a   = alu_a_reg[WIDTH-1];
    assign sign_b   = alu_b_reg[WIDTH-1];
    assign sign_r   = alu_out[WIDTH-1];
    assign cap_zero = (alu_out == '0);
    assign cap_neg  = sign_r;

    // Signed overflow is only meaningful for ADD and SUB.
    always_comb begin
        cap_ovf = 1'b0;
        if (op_reg == OP_ADD) begin
            cap_ovf = (sign_a == sign_b) && (sign_r != sign_a);
        end else if (op_reg == OP_SUB) begin
            cap_ovf = (sign_a != sign_b) && (sign_r != sign_a);
        end
    end

    // Control FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= OP_NOP;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= OP_NOP;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_zero_reg  <= 1'b0;
            rsp_neg_reg   <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
            rsp_err_reg   <= 1'b0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg        <= cmd_op;
                        alu_a_reg     <= cmd_a;
                        alu_b_reg     <= cmd_b;
                        cmd_ready_reg <= 1'b0;
                        if (cmd_op == OP_NOP) begin
                            // ALU stays held by alu_op=0; capture what it holds.
                            state_reg <= CAPTURE;
                        end else if (cmd_op > OP_LAST) begin
                            // Illegal opcode never reaches the ALU.
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= '0;
                            rsp_zero_reg  <= 1'b0;
                            rsp_neg_reg   <= 1'b0;
                            rsp_ovf_reg   <= 1'b0;
                            rsp_err_reg   <= 1'b1;
                        end else begin
                            state_reg  <= ISSUE;
                            alu_op_reg <= cmd_op;
                        end
                    end
                end

                ISSUE: begin
                    // The ALU registers its result on the edge that ends ISSUE.
                    alu_op_reg <= OP_NOP;
                    state_reg  <= CAPTURE;
                end

                CAPTURE: begin
                    rsp_data_reg  <= alu_out;
                    rsp_zero_reg  <= cap_zero;
                    rsp_neg_reg   <= cap_neg;
                    rsp_ovf_reg   <= cap_ovf;
                    rsp_err_reg   <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + CNT_W'(1);
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    alu_op_reg    <= OP_NOP;
                    cmd_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign rsp_neg   = rsp_neg_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign rsp_err   = rsp_err_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver
// Drives directed commands into alu_cmd_driver.
// A stand-in registered ALU is attached to the DUT.
// A transaction-level model predicts every response, and one compare process
// checks the DUT against that model on every falling edge.

module tb_alu_cmd_driver;

    localparam int WIDTH = 32;
    localparam int OP_W  = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_out_r = '0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_neg;
    logic             rsp_ovf;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    function automatic logic [WIDTH-1:0] alu_f(input logic [OP_W-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            5'd6:    return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // Stand-in ALU: registered result, holds while the opcode is NOP, never reset.
    always @(posedge clk) begin
        if (alu_op != '0) alu_out_r <= alu_f(alu_op, alu_a, alu_b);
    end

    // ---------------- reference model state ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic             err;
        int               lat;
    } rsp_t;

    rsp_t             exp_q[$];
    logic             busy        = 1'b0;
    logic [OP_W-1:0]  exp_alu_op  = '0;
    logic [WIDTH-1:0] exp_a       = '0;
    logic [WIDTH-1:0] exp_b       = '0;
    logic [CNT_W-1:0] model_count = '0;
    logic [WIDTH-1:0] model_alu_val = '0;

    logic [WIDTH-1:0] last_data;
    logic             last_zero, last_neg, last_ovf, last_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cmd_ready", 64'(cmd_ready), 64'(!busy));
            check("alu_op", 64'(alu_op), 64'(exp_alu_op));
            if (exp_alu_op != '0) begin
                check("alu_a", 64'(alu_a), 64'(exp_a));
                check("alu_b", 64'(alu_b), 64'(exp_b));
            end
            check("op_count", 64'(op_count), 64'(model_count));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_valid_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                    check("rsp_zero", 64'(rsp_zero), 64'(exp_q[0].zero));
                    check("rsp_neg",  64'(rsp_neg),  64'(exp_q[0].neg));
                    check("rsp_ovf",  64'(rsp_ovf),  64'(exp_q[0].ovf));
                    check("rsp_err",  64'(rsp_err),  64'(exp_q[0].err));
                end
            end
        end
    end

    // One full transaction: wait for ready, send, check latency, optionally stall, consume.
    task automatic do_cmd(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int hold);
        rsp_t   e;
        rsp_t   d;
        longint sa;
        longint sb;
        longint s;
        int     n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        rsp_ready = (hold == 0);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 0) begin
            e.data = model_alu_val; e.err = 1'b0; e.ovf = 1'b0; e.lat = 1;
        end else if (op > 6) begin
            e.data = '0; e.err = 1'b1; e.ovf = 1'b0; e.lat = 0;
        end else begin
            e.data = alu_f(op, a, b);
            model_alu_val = e.data;
            e.err = 1'b0;
            e.lat = 2;
            s = (op == 1) ? sa + sb : (op == 2) ? sa - sb : 64'sd0;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        e.zero = !e.err && (e.data == '0);
        e.neg  = !e.err && e.data[WIDTH-1];

        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        exp_q.push_back(e);
        busy       = 1'b1;
        exp_alu_op = (op >= 1 && op <= 6) ? op : '0;
        exp_a      = a;
        exp_b      = b;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            exp_alu_op = '0;
            n++;
        end
        check("rsp_latency", 64'(n), 64'(e.lat));
        last_data = rsp_data; last_zero = rsp_zero; last_neg = rsp_neg;
        last_ovf  = rsp_ovf;  last_err  = rsp_err;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) d = exp_q.pop_front();
        busy        = 1'b0;
        exp_alu_op  = '0;
        model_count = model_count + 1'b1;
        check("rsp_valid_after_hs", 64'(rsp_valid), 64'(0));
        $display("txn op=%0d a=0x%08h b=0x%08h -> data=0x%08h z=%0b n=%0b v=%0b e=%0b lat=%0d count=%0d",
                 op, a, b, last_data, last_zero, last_neg, last_ovf, last_err, n, op_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset_alu_op",    64'(alu_op),    64'(0));
        check("reset_alu_a",     64'(alu_a),     64'(0));
        check("reset_alu_b",     64'(alu_b),     64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_data",  64'(rsp_data),  64'(0));
        check("reset_rsp_flags", 64'({rsp_zero, rsp_neg, rsp_ovf, rsp_err}), 64'(0));
        check("reset_op_count",  64'(op_count),  64'(0));
        rst = 1'b0;

        // 1: ADD 5+7
        do_cmd(5'd1, 32'd5, 32'd7, 0);
        check("t1_data", 64'(last_data), 64'd12);
        check("t1_flags", 64'({last_zero, last_neg, last_ovf, last_err}), 64'(0));
        check("t1_count", 64'(op_count), 64'd1);

        // 2: SUB 0x80000000 - 1 overflows
        do_cmd(5'd2, 32'h8000_0000, 32'd1, 0);
        check("t2_data", 64'(last_data), 64'h7FFF_FFFF);
        check("t2_ovf",  64'(last_ovf), 64'd1);
        check("t2_neg",  64'(last_neg), 64'd0);

        // 3: NOR 0,0 then NOP returns the held result
        do_cmd(5'd6, 32'd0, 32'd0, 0);
        check("t3_nor_data", 64'(last_data), 64'hFFFF_FFFF);
        check("t3_nor_neg",  64'(last_neg), 64'd1);
        do_cmd(5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        check("t3_nop_data", 64'(last_data), 64'hFFFF_FFFF);
        check("t3_nop_neg",  64'(last_neg), 64'd1);
        check("wrap_count",  64'(op_count), 64'd0);

        // 4: illegal opcode
        do_cmd(5'd7, 32'd1, 32'd1, 0);
        check("t4_err",  64'(last_err), 64'd1);
        check("t4_data", 64'(last_data), 64'd0);

        // 5: XOR to zero with a 5-cycle response stall
        do_cmd(5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5);
        check("t5_data", 64'(last_data), 64'd0);
        check("t5_zero", 64'(last_zero), 64'd1);

        // Extra vectors: ADD overflow, SUB to -1, AND, OR, illegal 31 with stall, NOP
        do_cmd(5'd1, 32'h7FFF_FFFF, 32'd1, 0);
        check("x_add_ovf_data", 64'(last_data), 64'h8000_0000);
        check("x_add_ovf",      64'(last_ovf), 64'd1);
        do_cmd(5'd2, 32'd0, 32'd1, 1);
        check("x_sub_data", 64'(last_data), 64'hFFFF_FFFF);
        check("x_sub_ovf",  64'(last_ovf), 64'd0);
        do_cmd(5'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        check("x_and_data", 64'(last_data), 64'h00F0_1200);
        do_cmd(5'd4, 32'hF000_0000, 32'h0000_000F, 0);
        check("x_or_data",  64'(last_data), 64'hF000_000F);
        do_cmd(5'd31, 32'd9, 32'd9, 2);
        check("x_err31", 64'(last_err), 64'd1);
        do_cmd(5'd0, 32'd0, 32'd0, 0);
        check("x_nop_data", 64'(last_data), 64'hF000_000F);

        // 6: reset during ISSUE drops the command
        cmd_valid = 1'b1; cmd_op = 5'd1; cmd_a = 32'd3; cmd_b = 32'd4;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        busy       = 1'b1;
        exp_alu_op = 5'd1; exp_a = 32'd3; exp_b = 32'd4;
        check("t6_issue_alu_op", 64'(alu_op), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0; exp_alu_op = '0; exp_q.delete(); model_count = '0;
        model_alu_val = 32'd7;     // the ALU itself still computed 3+4 on that edge
        check("t6_alu_op",    64'(alu_op),    64'd0);
        check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_op_count",  64'(op_count),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        do_cmd(5'd0, 32'd0, 32'd0, 0);
        check("t6_nop_data", 64'(last_data), 64'd7);
        check("t6_count",    64'(op_count), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
